// File: rtl/bkpt_defs.sv
// Shared constants for the breakpoint controller: register map, CTRL fields
// and FSM state encodings.
package bkpt_defs;

    localparam logic [1:0] REG_MATCH  = 2'd0;
    localparam logic [1:0] REG_MASK   = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_PASS_LSB = 8;
    localparam int CTRL_PASS_MSB = 15;

    typedef enum logic [2:0] {
        ST_DISARMED = 3'd0,
        ST_ARMED    = 3'd1,
        ST_HALT_REQ = 3'd2,
        ST_HALTED   = 3'd3,
        ST_STEP     = 3'd4,
        ST_SKIP     = 3'd5
    } bp_state_t;

endpackage

// File: rtl/bkpt_ctrl_match.sv
// Masked address comparator: hit when every bit selected by mask agrees.
// A zero mask selects nothing, so every input hits.
module match #(
    parameter int W = 16
) (
    input  logic [W-1:0] inp_val,
    input  logic [W-1:0] match_val,
    input  logic [W-1:0] mask,
    output logic         hit
);

    assign hit = (((inp_val ^ match_val) & mask) == '0);

endmodule

// File: rtl/bkpt_ctrl.sv
// Breakpoint controller: value/mask registers, pass counter and the
// halt/resume/single-step handshake with the CPU core.
module bkpt_ctrl
    import bkpt_defs::*;
#(
    parameter int AW  = 16,
    parameter int PCW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cfg_we,
    input  logic [1:0]    cfg_addr,
    input  logic [15:0]   cfg_wdata,
    output logic [15:0]   cfg_rdata,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_fetch,
    output logic          halt_req,
    input  logic          halt_ack,
    input  logic          resume,
    input  logic          step,
    output logic [AW-1:0] hit_addr,
    output logic [2:0]    bp_state
);

    logic [AW-1:0]  match_reg;
    logic [AW-1:0]  mask_reg;
    logic           ctrl_en;
    logic [PCW-1:0] ctrl_pass;
    logic [PCW-1:0] pcnt;
    bp_state_t      state;
    logic           cmp_hit;
    logic           qual_hit;
    logic           ctrl_wr;

    match #(.W(AW)) u_match (
        .inp_val   (cpu_addr),
        .match_val (match_reg),
        .mask      (mask_reg),
        .hit       (cmp_hit)
    );

    assign qual_hit = cpu_fetch & cmp_hit;
    assign ctrl_wr  = cfg_we && (cfg_addr == REG_CTRL);
    assign bp_state = state;

    // Comparator value and mask registers; a write is used for comparison from the next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            match_reg <= '0;
            mask_reg  <= '0;
        end else if (cfg_we) begin
            if (cfg_addr == REG_MATCH) match_reg <= cfg_wdata;
            if (cfg_addr == REG_MASK)  mask_reg  <= cfg_wdata;
        end
    end

    // Breakpoint FSM with CTRL register, pass counter, hit address and registered halt_req.
    // A CTRL write outranks every other event in its cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_DISARMED;
            halt_req  <= 1'b0;
            hit_addr  <= '0;
            pcnt      <= '0;
            ctrl_en   <= 1'b0;
            ctrl_pass <= '0;
        end else if (ctrl_wr) begin
            ctrl_en   <= cfg_wdata[CTRL_EN];
            ctrl_pass <= cfg_wdata[CTRL_PASS_MSB:CTRL_PASS_LSB];
            pcnt      <= cfg_wdata[CTRL_PASS_MSB:CTRL_PASS_LSB];
            if (!cfg_wdata[CTRL_EN]) begin
                state    <= ST_DISARMED;
                halt_req <= 1'b0;
            end else if (state == ST_DISARMED) begin
                state <= ST_ARMED;
            end
        end else begin
            case (state)
                ST_ARMED: begin
                    if (qual_hit) begin
                        if (pcnt == '0) begin
                            state    <= ST_HALT_REQ;
                            halt_req <= 1'b1;
                            hit_addr <= cpu_addr;
                        end else begin
                            pcnt <= pcnt - PCW'(1);
                        end
                    end
                end
                ST_HALT_REQ: begin
                    if (halt_ack) state <= ST_HALTED;
                end
                ST_HALTED: begin
                    if (step) begin
                        state    <= ST_STEP;
                        halt_req <= 1'b0;
                        pcnt     <= ctrl_pass;
                    end else if (resume) begin
                        state    <= ST_SKIP;
                        halt_req <= 1'b0;
                        pcnt     <= ctrl_pass;
                    end
                end
                ST_STEP: begin
                    // The stepped instruction halts unconditionally, match or not.
                    if (cpu_fetch) begin
                        state    <= ST_HALT_REQ;
                        halt_req <= 1'b1;
                        hit_addr <= cpu_addr;
                    end
                end
                ST_SKIP: begin
                    // First fetch re-fetches the breakpoint address and must not re-trigger.
                    if (cpu_fetch) state <= ST_ARMED;
                end
                default: begin
                    state    <= ST_DISARMED;
                    halt_req <= 1'b0;
                end
            endcase
        end
    end

    // Register read mux, combinational from cfg_addr.
    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            REG_MATCH:  cfg_rdata = match_reg;
            REG_MASK:   cfg_rdata = mask_reg;
            REG_CTRL:   cfg_rdata = {ctrl_pass, 7'b0, ctrl_en};
            REG_STATUS: cfg_rdata = hit_addr;
            default:    cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_bkpt_ctrl.sv
// Directed table-driven bench for bkpt_ctrl plus an asynchronous reset sequence.
module tb_bkpt_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [15:0] cfg_rdata;
    logic [15:0] cpu_addr;
    logic        cpu_fetch;
    logic        halt_req;
    logic        halt_ack;
    logic        resume;
    logic        step;
    logic [15:0] hit_addr;
    logic [2:0]  bp_state;

    int total = 0;
    int bad   = 0;

    bkpt_ctrl #(.AW(16), .PCW(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .cpu_addr  (cpu_addr),
        .cpu_fetch (cpu_fetch),
        .halt_req  (halt_req),
        .halt_ack  (halt_ack),
        .resume    (resume),
        .step      (step),
        .hit_addr  (hit_addr),
        .bp_state  (bp_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [15:0] wdata;
        logic        fetch;
        logic [15:0] caddr;
        logic        ack;
        logic        res;
        logic        stp;
        logic        e_halt;
        logic [2:0]  e_st;
        logic [15:0] e_hit;
        logic [15:0] e_rd;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic we, input logic [1:0] addr, input logic [15:0] wdata,
                                input logic fetch, input logic [15:0] caddr, input logic ack,
                                input logic res, input logic stp, input logic e_halt,
                                input logic [2:0] e_st, input logic [15:0] e_hit,
                                input logic [15:0] e_rd);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.fetch = fetch; v.caddr = caddr;
        v.ack = ack; v.res = res; v.stp = stp; v.e_halt = e_halt; v.e_st = e_st;
        v.e_hit = e_hit; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cfg_we = 0; cfg_addr = 2'd3; cfg_wdata = 0; cpu_fetch = 0; cpu_addr = 0;
        halt_ack = 0; resume = 0; step = 0;
    endtask

    initial begin
        reset_n = 0;
        idle_inputs();

        //         we addr wdata   fe caddr   ak rs sp | halt st hit     rd
        // 1: arm and halt
        tv.push_back(mk(1, 0, 16'h8000, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h8000));
        tv.push_back(mk(1, 1, 16'hFFFF, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'hFFFF));
        tv.push_back(mk(1, 2, 16'h0001, 0, 16'h0000, 0, 0, 0, 0, 1, 16'h0000, 16'h0001));
        tv.push_back(mk(0, 3, 16'h0000, 1, 16'h8000, 0, 0, 0, 1, 2, 16'h8000, 16'h8000));
        tv.push_back(mk(0, 3, 16'h0000, 1, 16'h8000, 0, 0, 0, 1, 2, 16'h8000, 16'h8000));
        tv.push_back(mk(0, 3, 16'h0000, 0, 16'h0000, 1, 0, 0, 1, 3, 16'h8000, 16'h8000));
        tv.push_back(mk(0, 3, 16'h0000, 0, 16'h0000, 0, 0, 0, 1, 3, 16'h8000, 16'h8000));
        // 3: resume skips the first fetch, then re-triggers
        tv.push_back(mk(0, 3, 16'h0000, 0, 16'h0000, 0, 1, 0, 0, 5, 16'h8000, 16'h8000));
        tv.push_back(mk(0, 3, 16'h0000, 1, 16'h8000, 0, 0, 0, 0, 1, 16'h8000, 16'h8000));
        tv.push_back(mk(0, 3, 16'h0000, 1, 16'h8000, 0, 0, 0, 1, 2, 16'h8000, 16'h8000));
        tv.push_back(mk(0, 3, 16'h0000, 0, 16'h0000, 1, 0, 0, 1, 3, 16'h8000, 16'h8000));
        // 4: single step to a non-matching fetch
        tv.push_back(mk(0, 3, 16'h0000, 0, 16'h0000, 0, 0, 1, 0, 4, 16'h8000, 16'h8000));
        tv.push_back(mk(0, 3, 16'h0000, 0, 16'h8000, 0, 0, 0, 0, 4, 16'h8000, 16'h8000));
        tv.push_back(mk(0, 3, 16'h0000, 1, 16'h8002, 0, 0, 0, 1, 2, 16'h8002, 16'h8002));
        tv.push_back(mk(0, 3, 16'h0000, 0, 16'h0000, 1, 0, 0, 1, 3, 16'h8002, 16'h8002));
        tv.push_back(mk(0, 3, 16'h0000, 0, 16'h0000, 0, 1, 1, 0, 4, 16'h8002, 16'h8002));
        tv.push_back(mk(0, 3, 16'h0000, 1, 16'h1234, 0, 0, 0, 1, 2, 16'h1234, 16'h1234));
        tv.push_back(mk(0, 3, 16'h0000, 0, 16'h0000, 0, 1, 0, 1, 2, 16'h1234, 16'h1234));
        tv.push_back(mk(0, 3, 16'h0000, 0, 16'h0000, 1, 0, 0, 1, 3, 16'h1234, 16'h1234));
        tv.push_back(mk(0, 3, 16'h0000, 0, 16'h0000, 0, 1, 0, 0, 5, 16'h1234, 16'h1234));
        tv.push_back(mk(0, 3, 16'h0000, 1, 16'h8002, 0, 0, 0, 0, 1, 16'h1234, 16'h1234));
        // 2: pass count of 2 (non-fetch cycles never count)
        tv.push_back(mk(1, 2, 16'h0201, 0, 16'h0000, 0, 0, 0, 0, 1, 16'h1234, 16'h0201));
        tv.push_back(mk(0, 3, 16'h0000, 0, 16'h8000, 0, 0, 0, 0, 1, 16'h1234, 16'h1234));
        tv.push_back(mk(0, 3, 16'h0000, 1, 16'h8000, 0, 0, 0, 0, 1, 16'h1234, 16'h1234));
        tv.push_back(mk(0, 3, 16'h0000, 0, 16'h8000, 0, 0, 0, 0, 1, 16'h1234, 16'h1234));
        tv.push_back(mk(0, 3, 16'h0000, 1, 16'h8000, 0, 0, 0, 0, 1, 16'h1234, 16'h1234));
        tv.push_back(mk(0, 3, 16'h0000, 1, 16'h8000, 0, 0, 0, 1, 2, 16'h8000, 16'h8000));
        tv.push_back(mk(0, 3, 16'h0000, 0, 16'h0000, 1, 0, 0, 1, 3, 16'h8000, 16'h8000));
        // leaving HALTED reloads the pass count
        tv.push_back(mk(0, 3, 16'h0000, 0, 16'h0000, 0, 1, 0, 0, 5, 16'h8000, 16'h8000));
        tv.push_back(mk(0, 3, 16'h0000, 1, 16'h8000, 0, 0, 0, 0, 1, 16'h8000, 16'h8000));
        tv.push_back(mk(0, 3, 16'h0000, 1, 16'h8000, 0, 0, 0, 0, 1, 16'h8000, 16'h8000));
        tv.push_back(mk(0, 3, 16'h0000, 1, 16'h8000, 0, 0, 0, 0, 1, 16'h8000, 16'h8000));
        tv.push_back(mk(0, 3, 16'h0000, 1, 16'h8000, 0, 0, 0, 1, 2, 16'h8000, 16'h8000));
        // 5: disarm from HALT_REQ, then mask test
        tv.push_back(mk(1, 2, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h8000, 16'h0000));
        tv.push_back(mk(1, 1, 16'hFF00, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h8000, 16'hFF00));
        tv.push_back(mk(1, 0, 16'h1200, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h8000, 16'h1200));
        tv.push_back(mk(1, 2, 16'h0001, 0, 16'h0000, 0, 0, 0, 0, 1, 16'h8000, 16'h0001));
        tv.push_back(mk(0, 3, 16'h0000, 1, 16'h12AB, 0, 0, 0, 1, 2, 16'h12AB, 16'h12AB));
        tv.push_back(mk(0, 3, 16'h0000, 1, 16'h13AB, 0, 0, 0, 1, 2, 16'h12AB, 16'h12AB));
        // EN=1 write while halting keeps state; EN=0 write beats a halt_ack
        tv.push_back(mk(1, 2, 16'h0301, 0, 16'h0000, 0, 0, 0, 1, 2, 16'h12AB, 16'h0301));
        tv.push_back(mk(1, 2, 16'h0000, 0, 16'h0000, 1, 0, 0, 0, 0, 16'h12AB, 16'h0000));
        tv.push_back(mk(0, 3, 16'h0000, 1, 16'h12AB, 0, 0, 0, 0, 0, 16'h12AB, 16'h12AB));
        tv.push_back(mk(0, 3, 16'h0000, 0, 16'h0000, 1, 1, 1, 0, 0, 16'h12AB, 16'h12AB));
        tv.push_back(mk(1, 2, 16'h0001, 0, 16'h0000, 0, 0, 0, 0, 1, 16'h12AB, 16'h0001));
        tv.push_back(mk(0, 3, 16'h0000, 1, 16'h13AB, 0, 0, 0, 0, 1, 16'h12AB, 16'h12AB));
        tv.push_back(mk(0, 3, 16'h0000, 1, 16'h12FF, 0, 0, 0, 1, 2, 16'h12FF, 16'h12FF));
        tv.push_back(mk(0, 3, 16'h0000, 0, 16'h0000, 1, 0, 0, 1, 3, 16'h12FF, 16'h12FF));
        tv.push_back(mk(1, 2, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h12FF, 16'h0000));
        // MASK=0: any fetch hits
        tv.push_back(mk(1, 1, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h12FF, 16'h0000));
        tv.push_back(mk(1, 2, 16'h0001, 0, 16'h0000, 0, 0, 0, 0, 1, 16'h12FF, 16'h0001));
        tv.push_back(mk(0, 3, 16'h0000, 1, 16'hBEEF, 0, 0, 0, 1, 2, 16'hBEEF, 16'hBEEF));
        tv.push_back(mk(0, 3, 16'h0000, 0, 16'h0000, 1, 0, 0, 1, 3, 16'hBEEF, 16'hBEEF));

        // reset state
        #12;
        chk("rst_halt", 16'(halt_req), 16'h0);
        chk("rst_state", 16'(bp_state), 16'h0);
        chk("rst_hit", hit_addr, 16'h0);
        @(negedge clk);
        reset_n = 1;
        cyc();
        chk("idle_state", 16'(bp_state), 16'h0);

        for (int i = 0; i < tv.size(); i++) begin
            cfg_we = tv[i].we; cfg_addr = tv[i].addr; cfg_wdata = tv[i].wdata;
            cpu_fetch = tv[i].fetch; cpu_addr = tv[i].caddr;
            halt_ack = tv[i].ack; resume = tv[i].res; step = tv[i].stp;
            cyc();
            chk($sformatf("v%0d_halt", i), 16'(halt_req), 16'(tv[i].e_halt));
            chk($sformatf("v%0d_state", i), 16'(bp_state), 16'(tv[i].e_st));
            chk($sformatf("v%0d_hit", i), hit_addr, tv[i].e_hit);
            chk($sformatf("v%0d_rdata", i), cfg_rdata, tv[i].e_rd);
        end
        idle_inputs();

        // 6: asynchronous reset in the middle of a HALTED cycle
        cyc();
        chk("pre_rst_state", 16'(bp_state), 16'd3);
        chk("pre_rst_halt", 16'(halt_req), 16'h1);
        #2;
        reset_n = 0;
        #1;
        chk("arst_halt", 16'(halt_req), 16'h0);
        chk("arst_state", 16'(bp_state), 16'h0);
        chk("arst_hit", hit_addr, 16'h0);
        for (int a = 0; a < 4; a++) begin
            cfg_addr = 2'(a);
            #1;
            chk($sformatf("arst_reg%0d", a), cfg_rdata, 16'h0);
        end
        @(negedge clk);
        reset_n = 1;
        cpu_fetch = 1; cpu_addr = 16'h0000;
        cyc();
        chk("post_rst_state", 16'(bp_state), 16'h0);
        chk("post_rst_halt", 16'(halt_req), 16'h0);
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bkpt_ctrl.md
Name: bkpt_ctrl

Overview:
- Breakpoint controller for the BK debug path.
- Holds the breakpoint value and mask registers, and feeds them with the CPU fetch address into the combinational `match` comparator.
- Consumes the comparator's `hit` output and applies a pass count.
- Runs the halt/resume/single-step handshake with the CPU core.
- Config registers are accessed over a simple synchronous register port from the debug host.

Parameters:
- AW, 16, address/match width (matches the comparator width; only 16 is supported).
- PCW, 8, pass-counter width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cfg_we  in  1  register write strobe, single cycle
- cfg_addr  in  2  register select: 0=MATCH, 1=MASK, 2=CTRL, 3=STATUS (read-only)
- cfg_wdata  in  16  write data
- cfg_rdata  out  16  read data, combinational from cfg_addr
- cpu_addr  in  16  CPU bus address
- cpu_fetch  in  1  qualifies cpu_addr as an instruction fetch this cycle
- halt_req  out  1  registered request for the CPU to stall
- halt_ack  in  1  CPU is stalled at an instruction boundary
- resume  in  1  single-cycle pulse: leave halt
- step  in  1  single-cycle pulse: execute one instruction, then halt again
- hit_addr  out  16  cpu_addr of the fetch that triggered, held until the next trigger
- bp_state  out  3  current FSM state encoding

Behaviour:
- Reset values:
  - MATCH=0, MASK=0, CTRL=0, pass counter=0, hit_addr=0.
  - halt_req=0, state=DISARMED.
  - Reset asserted mid-halt drops halt_req asynchronously.
- CTRL layout: bit0 EN; bits[15:8] PASS (hits to skip before triggering); other bits read 0.
- Pass counter:
  - Loaded with PASS on a CTRL write and on leaving HALTED.
- Qualified hit:
  - Defined as cpu_fetch & match.hit, evaluated combinationally in cycle N.
  - Registered into the FSM decision at the cycle N edge.
- Trigger:
  - Occurs when a qualified hit is seen in ARMED and the pass counter is 0.
  - If the counter is non-zero, the qualified hit decrements it; no trigger.
- Trigger latency: halt_req=1 and hit_addr=cpu_addr(N) in cycle N+1.
- States:
  - DISARMED: halt_req=0. CTRL write with EN=1 goes to ARMED.
  - ARMED: trigger goes to HALT_REQ.
  - HALT_REQ: halt_req=1. halt_ack=1 goes to HALTED. Further fetches are ignored.
  - HALTED: halt_req=1.
    - step goes to STEP.
    - resume goes to SKIP.
    - If step and resume arrive in the same cycle, step wins.
  - STEP: halt_req=0. The first cpu_fetch goes to HALT_REQ, unconditionally (no match needed); hit_addr takes that fetch's address.
  - SKIP: halt_req=0. The first cpu_fetch is ignored (it re-fetches the breakpoint address), then the FSM goes to ARMED.
- Any CTRL write with EN=0:
  - Goes to DISARMED from every state and drops halt_req next cycle.
  - Has priority over all other events in that cycle.
- CTRL write with EN=1 while armed/halting/halted: the pass counter reloads; the state is unchanged.
- resume or step outside HALTED: ignored.
- A halt_ack outside HALT_REQ is ignored. halt_ack dropping while HALTED is ignored.
- MASK=0 means every qualified fetch hits.
- MATCH/MASK writes take effect for comparison in the next cycle.
- STATUS read: hit_addr.
- Register reads: MATCH/MASK/CTRL read back their stored values.
- bp_state encoding: DISARMED=0, ARMED=1, HALT_REQ=2, HALTED=3, STEP=4, SKIP=5.

Decomposition:
- Shared package/include `bkpt_defs`:
  - register address constants REG_MATCH/REG_MASK/REG_CTRL/REG_STATUS.
  - CTRL bit positions CTRL_EN, CTRL_PASS_LSB/MSB.
  - state encodings.
- Sub-module: one instance of the existing `match` comparator, with inp_val=cpu_addr, match_val=MATCH, mask=MASK.
- Everything else is flat: registers, pass counter, FSM.

Test Plan:
1. Arm and halt:
   - Stimulus: MATCH=0o100000, MASK=0xFFFF, CTRL=0x0001; fetch 0o100000 at cycle N.
   - Response: halt_req=1 at N+1, hit_addr=0o100000, state HALT_REQ.
   - Then halt_ack=1 -> HALTED.
2. Pass count:
   - Stimulus: CTRL=0x0201, then three fetches of the match address.
   - Response: the first two are ignored (counter 2->1->0); halt_req rises after the third.
   - Non-fetch cycles (cpu_fetch=0) with the matching address never trigger.
3. Resume skip:
   - Stimulus: from HALTED, resume pulse.
   - Response: halt_req=0 next cycle; the next fetch of the match address is ignored; the one after triggers again.
4. Single step:
   - Stimulus: from HALTED, step pulse, then a fetch of 0o100002 (non-matching).
   - Response: halt_req=1 the cycle after that fetch, hit_addr=0o100002.
   - With step+resume in the same cycle, the FSM enters STEP.
5. Mask and disarm:
   - Stimulus: MASK=0xFF00, MATCH=0x1200; fetch 0x12AB.
   - Response: triggers.
   - Then a CTRL write with 0 during HALT_REQ -> DISARMED, halt_req=0 next cycle.
6. Async reset:
   - Stimulus: assert reset_n=0 mid-cycle while HALTED.
   - Response: halt_req=0 immediately; all registers 0; state 0.
